traffic_light_fsm: RTL and testbench

Two-road traffic-light controller that consumes the divided `slow_clk` produced by the clock-divider stage and sequences the north-south (NS) and east-west (EW) signal heads. It runs entirely in the `clk` domain and turns each rising edge of `slow_clk` into a one-cycle tick. It counts every phase down in ticks and drives registered lamp outputs plus a remaining-time value for the display stage.

---
 rtl/tl_pkg.sv | 21 ++
 rtl/tick_edge_detect.sv | 15 +
 rtl/traffic_light_fsm.sv | 89 ++++++++
 tb/tb_traffic_light_fsm.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// tl_pkg: shared phase encoding, lamp codes and phase reload helpers for traffic_light_fsm
package tl_pkg;
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5
  } phase_e;
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;
  function automatic phase_e next_phase(phase_e p);
    return p == ALLRED_B ? NS_GREEN : phase_e'(p + 3'd1);
  endfunction
  function automatic int unsigned reload(phase_e p, int unsigned tg, int unsigned ty, int unsigned ta);
    return (p == NS_GREEN || p == EW_GREEN) ? tg - 1 :
           (p == NS_YELLOW || p == EW_YELLOW) ? ty - 1 : ta - 1;
  endfunction
endpackage

// File: rtl/tick_edge_detect.sv
// tick_edge_detect: one-cycle tick on each rising edge of slow_clk
//   clk, rst_n (async, active-low), slow_clk -> tick
//   history flop resets high so slow_clk already high at release gives no tick
module tick_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic slow_clk,
  output logic tick
);
  logic slow_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) slow_q <= 1'b1;
    else        slow_q <= slow_clk;
  assign tick = slow_clk & ~slow_q;
endmodule

// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: two-road signal sequencer counting phases in slow_clk ticks
//   in : clk, rst_n (async, active-low), slow_clk, ped_req (TL_PED_EN only)
//   out: ns_light/ew_light {R,Y,G}, countdown (ticks left minus one), phase, ped_walk (TL_PED_EN only)
//   macro TL_PED_EN adds the pedestrian request that shortens NS green and lights the walk lamp
module traffic_light_fsm
  import tl_pkg::*;
#(
  parameter int unsigned T_GREEN  = 25,
  parameter int unsigned T_YELLOW = 3,
  parameter int unsigned T_ALLRED = 2,
  parameter int unsigned T_PED    = 4,
  parameter int unsigned CNT_W    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slow_clk,
`ifdef TL_PED_EN
  input  logic             ped_req,
  output logic             ped_walk,
`endif
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [CNT_W-1:0] countdown,
  output logic [2:0]       phase
);
  logic             tick;
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ns_q, ns_d, ew_q, ew_d;
  tick_edge_detect u_tick (.clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .tick(tick));
`ifdef TL_PED_EN
  localparam logic [CNT_W-1:0] PED_LD = CNT_W'(T_PED - 1);
  logic ped_q, ped_d, walk_q, walk_d;
  logic ew_entry;
`endif
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    // illegal codes recover straight to clearance without waiting for a tick
    if (phase_q > ALLRED_B) begin
      phase_d = ALLRED_A;
      cnt_d   = CNT_W'(reload(ALLRED_A, T_GREEN, T_YELLOW, T_ALLRED));
    end else if (tick) begin
      if (cnt_q == '0) begin
        phase_d = next_phase(phase_q);
        cnt_d   = CNT_W'(reload(next_phase(phase_q), T_GREEN, T_YELLOW, T_ALLRED));
      end
`ifdef TL_PED_EN
      else if (phase_q == NS_GREEN && ped_q && cnt_q > PED_LD) cnt_d = PED_LD;
`endif
      else cnt_d = cnt_q - 1'b1;
    end
    ns_d = phase_d == NS_GREEN ? LAMP_G : phase_d == NS_YELLOW ? LAMP_Y : LAMP_R;
    ew_d = phase_d == EW_GREEN ? LAMP_G : phase_d == EW_YELLOW ? LAMP_Y : LAMP_R;
  end
`ifdef TL_PED_EN
  assign ew_entry = phase_d == EW_GREEN && phase_q != EW_GREEN;
  assign ped_d    = (ped_q | ped_req) & ~ew_entry;
  // walk is decided once at EW green entry and held for the whole phase
  assign walk_d   = phase_d == EW_GREEN && (ew_entry ? ped_q : walk_q);
  assign ped_walk = walk_q;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase_q <= ALLRED_B;
      cnt_q   <= CNT_W'(T_ALLRED - 1);
      ns_q    <= LAMP_R;
      ew_q    <= LAMP_R;
`ifdef TL_PED_EN
      ped_q   <= 1'b0;
      walk_q  <= 1'b0;
`endif
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
`ifdef TL_PED_EN
      ped_q   <= ped_d;
      walk_q  <= walk_d;
`endif
    end
  assign ns_light  = ns_q;
  assign ew_light  = ew_q;
  assign countdown = cnt_q;
  assign phase     = phase_q;
  assert property (@(posedge clk) disable iff (!rst_n)
    !(ns_q != LAMP_R && ew_q != LAMP_R) && T_PED >= 1 && T_PED <= T_GREEN);
endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb_traffic_light_fsm: directed self-checking bench for traffic_light_fsm
module tb_traffic_light_fsm;
  import tl_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       slow_clk = 1'b1;
  logic [2:0] ns_light, ew_light, phase;
  logic [3:0] countdown;
  int         checks = 0;
  int         failures = 0;
`ifdef TL_PED_EN
  logic       ped_req = 1'b0;
  logic       ped_walk;
`endif
  wire [12:0] obs = {phase, countdown, ns_light, ew_light};

  always #5 clk = ~clk;

  traffic_light_fsm #(.T_GREEN(5), .T_YELLOW(2), .T_ALLRED(1), .T_PED(2), .CNT_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .slow_clk(slow_clk),
`ifdef TL_PED_EN
    .ped_req(ped_req),
    .ped_walk(ped_walk),
`endif
    .ns_light(ns_light),
    .ew_light(ew_light),
    .countdown(countdown),
    .phase(phase)
  );

  function automatic logic [12:0] st(logic [2:0] p, logic [3:0] c);
    logic [2:0] ns = p == 3'd0 ? 3'b001 : p == 3'd1 ? 3'b010 : 3'b100;
    logic [2:0] ew = p == 3'd3 ? 3'b001 : p == 3'd4 ? 3'b010 : 3'b100;
    return {p, c, ns, ew};
  endfunction

  task automatic do_tick();
    @(negedge clk); slow_clk = 1'b1;
    repeat (4) @(negedge clk);
    slow_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (obs !== st(3'd5, 4'd0)) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, st(3'd5, 4'd0)); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (obs !== st(3'd5, 4'd0)) begin failures++; $display("FAIL release_no_tick got=%h exp=%h", obs, st(3'd5, 4'd0)); end
    slow_clk = 1'b0;
    repeat (3) @(negedge clk);
    do_tick();
    checks++; if (obs !== st(3'd0, 4'd4)) begin failures++; $display("FAIL first_tick got=%h exp=%h", obs, st(3'd0, 4'd4)); end
  endtask

  task automatic test_countdown();
    for (int c = 3; c >= 0; c--) begin
      @(negedge clk); slow_clk = 1'b1;
      checks++; if (obs !== st(3'd0, 4'(c + 1))) begin failures++; $display("FAIL cd_before_edge c=%0d got=%h exp=%h", c, obs, st(3'd0, 4'(c + 1))); end
      @(negedge clk);
      checks++; if (obs !== st(3'd0, 4'(c))) begin failures++; $display("FAIL cd_after_edge c=%0d got=%h exp=%h", c, obs, st(3'd0, 4'(c))); end
      repeat (3) @(negedge clk);
      slow_clk = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_full_cycle();
    logic [6:0] tbl [12] = '{
      {3'd1, 4'd1}, {3'd1, 4'd0}, {3'd2, 4'd0}, {3'd3, 4'd4}, {3'd3, 4'd3}, {3'd3, 4'd2},
      {3'd3, 4'd1}, {3'd3, 4'd0}, {3'd4, 4'd1}, {3'd4, 4'd0}, {3'd5, 4'd0}, {3'd0, 4'd4}};
    for (int i = 0; i < 12; i++) begin
      do_tick();
      checks++; if (obs !== st(tbl[i][6:4], tbl[i][3:0])) begin failures++; $display("FAIL cycle_step%0d got=%h exp=%h", i, obs, st(tbl[i][6:4], tbl[i][3:0])); end
    end
  endtask

  task automatic test_reset_mid();
    repeat (10) do_tick();
    checks++; if (obs !== st(3'd3, 4'd2)) begin failures++; $display("FAIL reach_ew_green got=%h exp=%h", obs, st(3'd3, 4'd2)); end
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    checks++; if (obs !== st(3'd5, 4'd0)) begin failures++; $display("FAIL async_reset got=%h exp=%h", obs, st(3'd5, 4'd0)); end
    @(negedge clk); rst_n = 1'b1;
    do_tick();
    checks++; if (obs !== st(3'd0, 4'd4)) begin failures++; $display("FAIL after_mid_reset got=%h exp=%h", obs, st(3'd0, 4'd4)); end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    force dut.phase_q = phase_e'(3'd6);
    #1 release dut.phase_q;
    checks++; if (phase !== 3'd6) begin failures++; $display("FAIL illegal_load got=%0d exp=6", phase); end
    @(negedge clk);
    checks++; if (obs !== st(3'd2, 4'd0)) begin failures++; $display("FAIL illegal_recover got=%h exp=%h", obs, st(3'd2, 4'd0)); end
    do_tick();
    checks++; if (obs !== st(3'd3, 4'd4)) begin failures++; $display("FAIL illegal_resume got=%h exp=%h", obs, st(3'd3, 4'd4)); end
  endtask

`ifdef TL_PED_EN
  task automatic test_ped();
    logic [6:0] tbl [9] = '{
      {3'd0, 4'd0}, {3'd1, 4'd1}, {3'd1, 4'd0}, {3'd2, 4'd0},
      {3'd3, 4'd4}, {3'd3, 4'd3}, {3'd3, 4'd2}, {3'd3, 4'd1}, {3'd3, 4'd0}};
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    do_tick();
    checks++; if (obs !== st(3'd0, 4'd4)) begin failures++; $display("FAIL ped_start got=%h exp=%h", obs, st(3'd0, 4'd4)); end
    @(negedge clk); ped_req = 1'b1;
    @(negedge clk); ped_req = 1'b0;
    do_tick();
    checks++; if (obs !== st(3'd0, 4'd1)) begin failures++; $display("FAIL ped_shorten got=%h exp=%h", obs, st(3'd0, 4'd1)); end
    for (int i = 0; i < 9; i++) begin
      do_tick();
      checks++; if (obs !== st(tbl[i][6:4], tbl[i][3:0])) begin failures++; $display("FAIL ped_step%0d got=%h exp=%h", i, obs, st(tbl[i][6:4], tbl[i][3:0])); end
      checks++; if (ped_walk !== (tbl[i][6:4] == 3'd3)) begin failures++; $display("FAIL ped_walk%0d got=%b exp=%b", i, ped_walk, tbl[i][6:4] == 3'd3); end
    end
    do_tick();
    checks++; if ({obs, ped_walk} !== {st(3'd4, 4'd1), 1'b0}) begin failures++; $display("FAIL ped_walk_end got=%h/%b exp=%h/0", obs, ped_walk, st(3'd4, 4'd1)); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_countdown();
    test_full_cycle();
    test_reset_mid();
    test_illegal();
`ifdef TL_PED_EN
    test_ped();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
